// File: rtl/mem_fill_unit.sv
// Single-line read fill unit: serves word reads from a one-line buffer, refilling it from a fixed-delay memory path on a miss.
// Hit/error response the cycle after accept; miss response WAIT_CYCLES+2 cycles after accept; response held until resp_ready.
module mem_fill_unit #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic         GCLK,
    input  logic         RESET,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    output logic [31:0]  mem_addr,
    input  logic [255:0] mem_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [255:0] resp_line,
    output logic [31:0]  resp_word,
    output logic         resp_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t         state;
    state_t         state_next;

    logic [26:0]    req_tag;
    logic [2:0]     word_idx;
    logic [3:0]     cnt;

    logic [26:0]    buf_tag;
    logic           buf_valid;
    logic [255:0]   buf_data;

    logic [255:0]   line_q;
    logic [31:0]    word_q;
    logic           err_q;

    logic [26:0]    in_tag;
    logic           in_zero;
    logic           in_hit;
    logic           cnt_done;

    // The two byte-offset bits select nothing inside a 32-bit word.
    logic           unused_byte_ofs;
    assign unused_byte_ofs = ^req_addr[1:0];

    function automatic logic [31:0] word_sel(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'b0} +: 32];
    endfunction

    assign in_tag   = req_addr[31:5];
    assign in_zero  = (in_tag == 27'd0);
    assign in_hit   = buf_valid && (buf_tag == in_tag);
    assign cnt_done = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (in_zero || in_hit) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (RESET) begin
            state     <= IDLE;
            req_tag   <= '0;
            word_idx  <= '0;
            cnt       <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            line_q    <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_tag  <= in_tag;
                        word_idx <= req_addr[4:2];
                        cnt      <= '0;
                        // Line 0 doubles as the idle code on mem_addr, so it is rejected outright.
                        if (in_zero) begin
                            line_q <= '0;
                            word_q <= '0;
                            err_q  <= 1'b1;
                        end else if (in_hit) begin
                            line_q <= buf_data;
                            word_q <= word_sel(buf_data, req_addr[4:2]);
                            err_q  <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!cnt_done) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    buf_data  <= mem_data;
                    buf_tag   <= req_tag;
                    buf_valid <= 1'b1;
                    line_q    <= mem_data;
                    word_q    <= word_sel(mem_data, word_idx);
                    err_q     <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        line_q <= '0;
                        word_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_addr   = (state == WAIT) ? {req_tag, 5'b0} : 32'h0;
    assign resp_line  = line_q;
    assign resp_word  = word_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_fill_unit.sv
// Randomized bench for mem_fill_unit: a WAIT_CYCLES=4 instance against a line-buffer reference model,
// plus a WAIT_CYCLES=1 instance for the short-window miss.
module tb_mem_fill_unit;

    localparam int W0 = 4;
    localparam int W1 = 1;

    logic         GCLK = 1'b0;
    logic         RESET;

    logic         req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0]  req_addr, mem_addr, resp_word;
    logic [255:0] mem_data, resp_line;

    logic         b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0]  b_req_addr, b_mem_addr, b_resp_word;
    logic [255:0] b_mem_data, b_resp_line;

    int           n_chk = 0;
    int           n_pass = 0;
    logic [31:0]  seed = 32'h0;

    // Reference line buffer
    bit           m_vld;
    logic [26:0]  m_tag;
    logic [255:0] m_data;

    always #5 GCLK = ~GCLK;

    mem_fill_unit #(.WAIT_CYCLES(W0)) dut (
        .GCLK(GCLK), .RESET(RESET),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_line(resp_line), .resp_word(resp_word), .resp_err(resp_err)
    );

    mem_fill_unit #(.WAIT_CYCLES(W1)) dut_b (
        .GCLK(GCLK), .RESET(RESET),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_line(b_resp_line), .resp_word(b_resp_word), .resp_err(b_resp_err)
    );

    function automatic logic [255:0] line_fn(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = (a * 32'h9E37_79B1) ^ seed ^ (32'h1111_1111 * 32'(i + 1));
        end
        return l;
    endfunction

    // Memory delay path: returns the line for the last address it was shown.
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;
    always @(posedge GCLK) begin
        if (mem_addr != 32'h0)   last_a <= mem_addr;
        if (b_mem_addr != 32'h0) last_b <= b_mem_addr;
    end
    assign mem_data   = line_fn(last_a);
    assign b_mem_data = line_fn(last_b);

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge GCLK);
        RESET = 1'b1;
        req_valid = 1'b0; resp_ready = 1'b0;
        b_req_valid = 1'b0; b_resp_ready = 1'b0;
        @(posedge GCLK);
        @(negedge GCLK);
        RESET = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_line", resp_line, 0);
        chk("rst_resp_word", resp_word, 0);
        chk("rst_b_req_ready", b_req_ready, 1);
        chk("rst_b_resp_valid", b_resp_valid, 0);
        m_vld = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] addr, input int hold);
        logic [26:0]  tg;
        int           idx, exp_lat, lat, nz, first_nz;
        bit           exp_err, miss;
        logic [255:0] exp_line;
        tg       = addr[31:5];
        idx      = int'(addr[4:2]);
        exp_err  = (tg == 27'd0);
        miss     = !exp_err && !(m_vld && (m_tag == tg));
        exp_line = exp_err ? 256'h0 : (miss ? line_fn({tg, 5'b0}) : m_data);
        exp_lat  = miss ? W0 + 2 : 1;

        @(negedge GCLK);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge GCLK);
        lat = 0; nz = 0; first_nz = 0;
        while (lat < 40) begin
            @(negedge GCLK);
            lat++;
            req_valid = 1'($urandom);
            req_addr  = $urandom;
            if (mem_addr != 32'h0) begin
                nz++;
                if (first_nz == 0) first_nz = lat;
                chk("mem_addr_line", mem_addr, {tg, 5'b0});
            end
            chk("req_ready_busy", req_ready, 0);
            if (resp_valid) break;
        end
        chk("resp_latency", lat, exp_lat);
        chk("mem_window_len", nz, miss ? W0 : 0);
        if (miss) chk("mem_window_start", first_nz, 1);
        chk("resp_err", resp_err, exp_err);
        chk("resp_line", resp_line, exp_line);
        chk("resp_word", resp_word, exp_line[idx*32 +: 32]);

        repeat (hold) begin
            @(negedge GCLK);
            req_valid = 1'($urandom);
            req_addr  = $urandom;
            chk("hold_resp_valid", resp_valid, 1);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_mem_addr", mem_addr, 0);
            chk("hold_resp_line", resp_line, exp_line);
            chk("hold_resp_word", resp_word, exp_line[idx*32 +: 32]);
            chk("hold_resp_err", resp_err, exp_err);
        end

        // A request offered in the completing cycle must be ignored.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0000_4444;
        @(posedge GCLK);
        @(negedge GCLK);
        resp_ready = 1'b0;
        chk("done_resp_valid", resp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_mem_addr", mem_addr, 0);
        req_valid = 1'b0;

        if (miss) begin
            m_vld  = 1'b1;
            m_tag  = tg;
            m_data = exp_line;
        end
    endtask

    task automatic abort_in_wait(input logic [31:0] addr);
        @(negedge GCLK);
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge GCLK);
        @(negedge GCLK);
        req_valid = 1'b0;
        chk("abort_wait1_addr", mem_addr, {addr[31:5], 5'b0});
        @(negedge GCLK);
        chk("abort_wait2_addr", mem_addr, {addr[31:5], 5'b0});
        RESET = 1'b1;
        resp_ready = 1'b1;
        @(posedge GCLK);
        @(negedge GCLK);
        RESET = 1'b0;
        resp_ready = 1'b0;
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_req_ready", req_ready, 1);
        m_vld = 1'b0;
        repeat (W0 + 3) begin
            @(negedge GCLK);
            chk("abort_no_resp", resp_valid, 0);
        end
    endtask

    initial begin
        int           r, lat, nz;
        logic [31:0]  a;
        logic [255:0] bl;
        RESET = 1'b1;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;
        seed = $urandom;
        m_vld = 1'b0; m_tag = '0; m_data = '0;

        do_reset();
        do_req(32'h0000_1044, 0);
        do_req(32'h0000_105C, 10);
        do_req(32'h0000_0010, 2);
        do_req(32'h0000_1040, 1);
        abort_in_wait(32'h0000_7A48);
        do_req(32'h0000_7A48, 0);

        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       a = {m_tag, 5'($urandom)};
                1:       a = 32'($urandom_range(0, 31));
                2:       a = $urandom;
                default: a = (32'($urandom_range(1, 3)) << 5) | 32'($urandom_range(0, 31));
            endcase
            do_req(a, $urandom_range(0, 3));
        end

        // Short-window instance: miss on line 0x2000
        @(negedge GCLK);
        b_req_valid = 1'b1;
        b_req_addr  = 32'h0000_2000;
        @(posedge GCLK);
        lat = 0; nz = 0;
        while (lat < 20) begin
            @(negedge GCLK);
            b_req_valid = 1'b0;
            lat++;
            if (b_mem_addr != 32'h0) nz++;
            if (b_resp_valid) break;
        end
        bl = line_fn(32'h0000_2000);
        chk("w1_latency", lat, W1 + 2);
        chk("w1_window_len", nz, W1);
        chk("w1_resp_word", b_resp_word, bl[31:0]);
        chk("w1_resp_err", b_resp_err, 0);
        b_resp_ready = 1'b1;
        @(posedge GCLK);
        @(negedge GCLK);
        b_resp_ready = 1'b0;
        chk("w1_done_req_ready", b_req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
